// File: rtl/inst_fetch_queue.sv
// Two-in / one-out instruction buffer feeding the control-unit decoder.
// Splits the head instruction into opcode and jump-offset fields.
module inst_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int IW    = 16,
    parameter int PW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_in,
    input  logic [1:0]               fetch_vld_in,
    input  logic [IW-1:0]            fetch_inst0_in,
    input  logic [IW-1:0]            fetch_inst1_in,
    input  logic [PW-1:0]            fetch_pc0_in,
    output logic                     fetch_rdy_out,
    input  logic                     dec_rdy_in,
    output logic                     dec_vld_out,
    output logic [3:0]               opco_out,
    output logic [1:0]               jmp_off_out,
    output logic [IW-1:0]            inst_out,
    output logic [PW-1:0]            pc_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = IW + PW;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_nxt;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    n_push;
    logic          pop;
    logic [EW-1:0] head;
    logic [PW-1:0] pc1;

    // Readiness is based on the registered count only, never on a same-cycle pop.
    assign fetch_rdy_out = (count <= CW'(DEPTH - 2));
    assign dec_vld_out   = (count != '0);
    assign pop           = dec_vld_out && dec_rdy_in;
    assign wr_nxt        = wr_ptr + AW'(1);
    assign pc1           = fetch_pc0_in + PW'(1);
    assign head          = mem[rd_ptr];
    assign count_out     = count;

    always_comb begin
        n_push = 2'd0;
        if (fetch_rdy_out) begin
            unique case (fetch_vld_in)
                2'b01:   n_push = 2'd1;
                2'b11:   n_push = 2'd2;
                default: n_push = 2'd0;
            endcase
        end
    end

    // Empty queue presents an all-zero (NOP) head to the decoder.
    always_comb begin
        inst_out = '0;
        pc_out   = '0;
        if (dec_vld_out) begin
            inst_out = head[IW-1:0];
            pc_out   = head[EW-1:IW];
        end
    end

    assign opco_out    = inst_out[IW-1:IW-4];
    assign jmp_off_out = inst_out[IW-5:IW-6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(n_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush_in) begin
            if (n_push != 2'd0) begin
                mem[wr_ptr] <= {fetch_pc0_in, fetch_inst0_in};
            end
            if (n_push == 2'd2) begin
                mem[wr_nxt] <= {pc1, fetch_inst1_in};
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue.
// Scoreboard model plus per-scenario directed checks.
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;
    localparam int IW    = 16;
    localparam int PW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_in;
    logic [1:0]    fetch_vld_in;
    logic [IW-1:0] fetch_inst0_in;
    logic [IW-1:0] fetch_inst1_in;
    logic [PW-1:0] fetch_pc0_in;
    logic          fetch_rdy_out;
    logic          dec_rdy_in;
    logic          dec_vld_out;
    logic [3:0]    opco_out;
    logic [1:0]    jmp_off_out;
    logic [IW-1:0] inst_out;
    logic [PW-1:0] pc_out;
    logic [3:0]    count_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [IW+PW-1:0] sb[$];

    inst_fetch_queue #(.DEPTH(DEPTH), .IW(IW), .PW(PW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_in       (flush_in),
        .fetch_vld_in   (fetch_vld_in),
        .fetch_inst0_in (fetch_inst0_in),
        .fetch_inst1_in (fetch_inst1_in),
        .fetch_pc0_in   (fetch_pc0_in),
        .fetch_rdy_out  (fetch_rdy_out),
        .dec_rdy_in     (dec_rdy_in),
        .dec_vld_out    (dec_vld_out),
        .opco_out       (opco_out),
        .jmp_off_out    (jmp_off_out),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .count_out      (count_out)
    );

    always #5 clk = ~clk;

    // Scoreboard: inputs are stable at the falling edge, so the coming
    // rising edge's push/pop is decided here.
    always @(negedge clk) begin
        logic             exp_rdy;
        logic [IW+PW-1:0] e;
        int               sz;
        if (!rst_n || flush_in) begin
            sb.delete();
        end else begin
            sz      = sb.size();
            exp_rdy = (DEPTH - sz) >= 2;
            n_cmp++;
            if (count_out !== 4'(sz)) begin
                n_err++;
                $display("FAIL sb_count got %0d exp %0d", count_out, sz);
            end
            n_cmp++;
            if (fetch_rdy_out !== exp_rdy) begin
                n_err++;
                $display("FAIL sb_rdy got %b exp %b", fetch_rdy_out, exp_rdy);
            end
            n_cmp++;
            if (dec_vld_out !== (sz != 0)) begin
                n_err++;
                $display("FAIL sb_vld got %b exp %b", dec_vld_out, sz != 0);
            end
            if (sz == 0) begin
                n_cmp++;
                if ({pc_out, inst_out, opco_out, jmp_off_out} !== '0) begin
                    n_err++;
                    $display("FAIL sb_empty_head got pc %h inst %h", pc_out, inst_out);
                end
            end else if (dec_rdy_in) begin
                e = sb.pop_front();
                n_cmp++;
                if ({pc_out, inst_out} !== e || opco_out !== e[15:12]
                    || jmp_off_out !== e[11:10]) begin
                    n_err++;
                    $display("FAIL sb_head got pc %h inst %h exp pc %h inst %h",
                             pc_out, inst_out, e[31:16], e[15:0]);
                end
            end
            if (exp_rdy && fetch_vld_in == 2'b01) begin
                sb.push_back({fetch_pc0_in, fetch_inst0_in});
            end else if (exp_rdy && fetch_vld_in == 2'b11) begin
                sb.push_back({fetch_pc0_in, fetch_inst0_in});
                sb.push_back({fetch_pc0_in + 16'd1, fetch_inst1_in});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [15:0] i0,
                         input logic [15:0] i1, input logic [15:0] pc);
        fetch_vld_in   = v;
        fetch_inst0_in = i0;
        fetch_inst1_in = i1;
        fetch_pc0_in   = pc;
    endtask

    task automatic drain();
        dec_rdy_in = 1'b1;
        drive(2'b00, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 20 && count_out != 0; i++) tick();
        n_cmp++;
        if (count_out !== 4'd0) begin
            n_err++;
            $display("FAIL drain_timeout got %0d exp 0", count_out);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        flush_in   = 1'b0;
        dec_rdy_in = 1'b0;
        drive(2'b00, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        n_cmp++;
        if ({dec_vld_out, count_out, opco_out, inst_out, pc_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outs got vld %b cnt %0d inst %h pc %h",
                     dec_vld_out, count_out, inst_out, pc_out);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (fetch_rdy_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rdy got %b exp 1", fetch_rdy_out);
        end
    endtask

    task automatic test_basic();
        dec_rdy_in = 1'b1;
        drive(2'b11, 16'h1123, 16'hF800, 16'h0040);
        tick();
        drive(2'b00, 16'h0, 16'h0, 16'h0);
        n_cmp++;
        if (opco_out !== 4'b0001 || pc_out !== 16'h0040 || dec_vld_out !== 1'b1) begin
            n_err++;
            $display("FAIL basic_first got opco %b pc %h exp 0001 0040", opco_out, pc_out);
        end
        tick();
        n_cmp++;
        if (opco_out !== 4'b1111 || jmp_off_out !== 2'b10 || pc_out !== 16'h0041) begin
            n_err++;
            $display("FAIL basic_second got opco %b jmp %b pc %h exp 1111 10 0041",
                     opco_out, jmp_off_out, pc_out);
        end
        tick();
        n_cmp++;
        if (dec_vld_out !== 1'b0) begin
            n_err++;
            $display("FAIL basic_empty got vld %b exp 0", dec_vld_out);
        end
    endtask

    task automatic test_fill();
        dec_rdy_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 16'h2000 + 16'(k), 16'h3400 + 16'(k), 16'h0100 + 16'(2 * k));
            tick();
            n_cmp++;
            if (count_out !== 4'(2 * (k + 1))) begin
                n_err++;
                $display("FAIL fill_count got %0d exp %0d", count_out, 2 * (k + 1));
            end
        end
        n_cmp++;
        if (fetch_rdy_out !== 1'b0) begin
            n_err++;
            $display("FAIL full_rdy got %b exp 0", fetch_rdy_out);
        end
        drive(2'b11, 16'hDEAD, 16'hBEEF, 16'h0F00);
        tick();
        n_cmp++;
        if (count_out !== 4'd8) begin
            n_err++;
            $display("FAIL full_hold got %0d exp 8", count_out);
        end
        drain();
    endtask

    task automatic test_rdy_block();
        dec_rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 16'h5000 + 16'(k), 16'h6C00 + 16'(k), 16'h0200 + 16'(2 * k));
            tick();
        end
        drive(2'b01, 16'h7000, 16'h0, 16'h0206);
        tick();
        n_cmp++;
        if (count_out !== 4'd7 || fetch_rdy_out !== 1'b0) begin
            n_err++;
            $display("FAIL seven_state got cnt %0d rdy %b exp 7 0", count_out, fetch_rdy_out);
        end
        dec_rdy_in = 1'b1;
        drive(2'b01, 16'h8000, 16'h0, 16'h0300);
        tick();
        dec_rdy_in = 1'b0;
        drive(2'b00, 16'h0, 16'h0, 16'h0);
        n_cmp++;
        if (count_out !== 4'd6) begin
            n_err++;
            $display("FAIL blocked_push got %0d exp 6", count_out);
        end
        drain();
    endtask

    task automatic test_wrap();
        flush_in = 1'b1;
        tick();
        flush_in   = 1'b0;
        dec_rdy_in = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive(2'b01, 16'h9000 + 16'(k), 16'h0, 16'h0400 + 16'(k));
            tick();
        end
        drive(2'b00, 16'h0, 16'h0, 16'h0);
        tick();
        drive(2'b11, 16'hA400, 16'hB800, 16'h0500);
        tick();
        drive(2'b00, 16'h0, 16'h0, 16'h0);
        n_cmp++;
        if (pc_out !== 16'h0500 || inst_out !== 16'hA400) begin
            n_err++;
            $display("FAIL wrap_first got pc %h inst %h exp 0500 a400", pc_out, inst_out);
        end
        tick();
        n_cmp++;
        if (pc_out !== 16'h0501 || inst_out !== 16'hB800) begin
            n_err++;
            $display("FAIL wrap_second got pc %h inst %h exp 0501 b800", pc_out, inst_out);
        end
        drain();
    endtask

    task automatic test_flush();
        dec_rdy_in = 1'b0;
        drive(2'b11, 16'h1000, 16'h2000, 16'h0600);
        tick();
        drive(2'b11, 16'h3000, 16'h4000, 16'h0602);
        tick();
        drive(2'b01, 16'h5000, 16'h0, 16'h0604);
        tick();
        flush_in   = 1'b1;
        dec_rdy_in = 1'b1;
        drive(2'b11, 16'hC000, 16'hD000, 16'h0700);
        tick();
        flush_in = 1'b0;
        drive(2'b00, 16'h0, 16'h0, 16'h0);
        n_cmp++;
        if (count_out !== 4'd0 || dec_vld_out !== 1'b0 || opco_out !== 4'd0) begin
            n_err++;
            $display("FAIL flush got cnt %0d vld %b opco %b exp 0 0 0",
                     count_out, dec_vld_out, opco_out);
        end
    endtask

    task automatic test_illegal();
        dec_rdy_in = 1'b1;
        drive(2'b10, 16'hE000, 16'hE400, 16'h0800);
        tick();
        drive(2'b00, 16'h0, 16'h0, 16'h0);
        tick();
        n_cmp++;
        if (count_out !== 4'd0 || dec_vld_out !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_vld got cnt %0d vld %b exp 0 0", count_out, dec_vld_out);
        end
    endtask

    task automatic test_reset_mid();
        dec_rdy_in = 1'b0;
        drive(2'b11, 16'h1400, 16'h2800, 16'h0900);
        tick();
        drive(2'b01, 16'h3C00, 16'h0, 16'h0902);
        tick();
        drive(2'b00, 16'h0, 16'h0, 16'h0);
        n_cmp++;
        if (count_out !== 4'd3) begin
            n_err++;
            $display("FAIL mid_pre got %0d exp 3", count_out);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dec_vld_out, count_out, opco_out, jmp_off_out, inst_out, pc_out} !== '0) begin
            n_err++;
            $display("FAIL mid_reset got vld %b cnt %0d inst %h pc %h",
                     dec_vld_out, count_out, inst_out, pc_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (fetch_rdy_out !== 1'b1 || count_out !== 4'd0) begin
            n_err++;
            $display("FAIL mid_release got rdy %b cnt %0d", fetch_rdy_out, count_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_rdy_block();
        test_wrap();
        test_flush();
        test_illegal();
        test_reset_mid();
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction buffer directly upstream of the control-unit decoder.
- Accepts fetch bundles of up to two 16-bit instructions per cycle and presents one instruction per cycle to decode.
- Splits the head instruction into opcode [15:12] and jump-offset [11:10] fields for the decoder.
- Absorbs decode stalls and is cleared by a front-end redirect (flush).

Parameters:
- DEPTH, 8, number of entries; power of 2, minimum 4.
- IW, 16, instruction width in bits.
- PW, 16, PC width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_in  input  1  synchronous clear of all entries (jump/branch redirect).
- fetch_vld_in  input  2  per-slot valid; bit0 = slot0, bit1 = slot1.
- fetch_inst0_in  input  IW  slot0 instruction (older).
- fetch_inst1_in  input  IW  slot1 instruction (younger).
- fetch_pc0_in  input  PW  PC of slot0; slot1 PC = fetch_pc0_in + 1.
- fetch_rdy_out  output  1  queue can accept a full 2-instruction bundle this cycle.
- dec_rdy_in  input  1  decoder accepts the head instruction this cycle.
- dec_vld_out  output  1  head entry valid.
- opco_out  output  4  head instruction [15:12].
- jmp_off_out  output  2  head instruction [11:10].
- inst_out  output  IW  full head instruction.
- pc_out  output  PW  PC of head instruction.
- count_out  output  log2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Write and read pointers = 0, count = 0, dec_vld_out = 0.
  - opco_out, jmp_off_out, inst_out, pc_out = 0, so the decoder sees opcode 0000 (NOP).
  - fetch_rdy_out = 1 from the first cycle after reset release.
- Storage: DEPTH x (IW+PW) registered array, with read and write pointers of width log2(DEPTH) that wrap modulo DEPTH.
- Push count per cycle:
  - fetch_vld_in = 01 pushes slot0 only.
  - fetch_vld_in = 11 pushes slot0 then slot1, in order.
  - fetch_vld_in = 10 is illegal and pushes nothing.
  - 00 pushes nothing.
- Push acceptance:
  - A push occurs only when fetch_rdy_out = 1.
  - fetch_rdy_out = (DEPTH - count) >= 2, computed from the current registered count only; a same-cycle pop does not raise it.
  - If fetch_vld_in is nonzero while fetch_rdy_out = 0, the bundle is dropped and fetch must hold it.
- Pop: occurs when dec_vld_out && dec_rdy_in; the read pointer advances by 1.
- Head outputs:
  - Driven combinationally from the entry at the read pointer.
  - dec_vld_out = (count != 0).
  - When count = 0, all head fields are forced to 0.
- Latency: an instruction written at rising edge N appears on the head outputs in the cycle after edge N if the queue was empty. There is no same-cycle bypass from fetch to decode.
- Simultaneous push and pop: next count = count + pushes - pop. Entries pushed this cycle are never the entry popped this cycle.
- Full: count never exceeds DEPTH. With count = DEPTH-1, fetch_rdy_out = 0, so a single push is also blocked.
- Empty: dec_rdy_in is ignored when count = 0; there is no underflow and the read pointer is unchanged.
- Wrap-around: a two-entry push straddling index DEPTH-1 writes slot0 at DEPTH-1 and slot1 at 0.
- Flush:
  - flush_in = 1 at a rising edge sets pointers = 0 and count = 0.
  - Any push or pop in the same cycle is discarded.
  - dec_vld_out = 0 in the following cycle.
  - Flush has priority over push and pop; reset has priority over flush.
- Reset mid-operation: all state is cleared immediately, regardless of in-flight handshakes.
- count_out is the registered count and is updated on each clock edge.

Test Plan:
- Reset, then push {vld=11, inst0=16'h1123, inst1=16'hF800, pc0=16'h0040} with dec_rdy_in = 1:
  - Next cycle: opco_out = 0001, pc_out = 0040.
  - Following cycle: opco_out = 1111, jmp_off_out = 10, pc_out = 0041.
  - Then dec_vld_out = 0.
- Hold dec_rdy_in = 0 and push vld=11 bundles every cycle (DEPTH = 8):
  - count_out reads 2, 4, 6, 8.
  - fetch_rdy_out drops when count = 8; the next bundle is not written and count stays 8.
- Fill to 7, then release dec_rdy_in for one cycle while pushing vld=01:
  - fetch_rdy_out is 0 (count 7), so no push occurs.
  - Pop occurs and count becomes 6.
- Wrap: advance the pointers to 7, then push a vld=11 bundle:
  - Both entries pop in order with PCs n and n+1.
  - No corruption at index 0.
- With 5 entries, assert flush_in together with push vld=11 and dec_rdy_in = 1:
  - Next cycle: count_out = 0, dec_vld_out = 0, opco_out = 0000.
- Assert vld=10 with the queue empty: count stays 0. Also assert rst_n low mid-stream with 3 entries: all outputs are 0 immediately.
